// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory arbiter slice.
package dmem_pkg;
    localparam int unsigned AW_DEF     = 16;
    localparam int unsigned DW_DEF     = 16;
    localparam int unsigned PRIO_RR    = 0;
    localparam int unsigned PRIO_FIXED = 1;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_DBG = 1'b1
    } port_e;
endpackage

// File: rtl/dmem_rd_return.sv
// Per-port read return path: one-cycle pending flag, hold register and rdata mux.
module dmem_rd_return #(
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          issue,
    input  logic [DW-1:0] mem_dout,
    output logic          rvalid,
    output logic [DW-1:0] rdata
);
    logic          rd_pend;
    logic [DW-1:0] hold;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_pend <= 1'b0;
            hold    <= '0;
        end else begin
            rd_pend <= issue;
            if (rd_pend) hold <= mem_dout;
        end
    end

    // BRAM data is passed straight through in the return cycle, then held.
    always_comb begin
        rvalid = rd_pend;
        rdata  = rd_pend ? mem_dout : hold;
    end
endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data-memory BRAM.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned AW        = AW_DEF,
    parameter int unsigned DW        = DW_DEF,
    parameter int unsigned PRIO_MODE = PRIO_RR
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          rvalid0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata1,
    output logic          mem_ena,
    output logic          mem_wea,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);
    port_e last_gnt;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst) begin
            if (req0 && req1) begin
                // Tie: fixed mode favours the CPU, round-robin favours the port not served last.
                if (PRIO_MODE == PRIO_FIXED || last_gnt == PORT_DBG) gnt0 = 1'b1;
                else                                                 gnt1 = 1'b1;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    always_comb begin
        mem_ena  = 1'b0;
        mem_wea  = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        if (gnt0) begin
            mem_ena  = 1'b1;
            mem_wea  = we0;
            mem_addr = addr0;
            mem_din  = wdata0;
        end else if (gnt1) begin
            mem_ena  = 1'b1;
            mem_wea  = we1;
            mem_addr = addr1;
            mem_din  = wdata1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      last_gnt <= PORT_CPU;
        else if (gnt0) last_gnt <= PORT_CPU;
        else if (gnt1) last_gnt <= PORT_DBG;
    end

    dmem_rd_return #(.DW(DW)) u_ret0 (
        .clk      (clk),
        .rst      (rst),
        .issue    (gnt0 & ~we0),
        .mem_dout (mem_dout),
        .rvalid   (rvalid0),
        .rdata    (rdata0)
    );

    dmem_rd_return #(.DW(DW)) u_ret1 (
        .clk      (clk),
        .rst      (rst),
        .issue    (gnt1 & ~we1),
        .mem_dout (mem_dout),
        .rvalid   (rvalid1),
        .rdata    (rdata1)
    );
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench: round-robin instance (index 0) and fixed-priority instance (index 1).
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        req0 [2], we0 [2], req1 [2], we1 [2];
    logic [15:0] addr0 [2], wdata0 [2], addr1 [2], wdata1 [2];
    logic        gnt0 [2], gnt1 [2], rvalid0 [2], rvalid1 [2];
    logic [15:0] rdata0 [2], rdata1 [2];
    logic        mem_ena [2], mem_wea [2];
    logic [15:0] mem_addr [2], mem_din [2], mem_dout [2];
    logic [15:0] mem [2][256];

    logic [15:0] q [4][$];
    logic [15:0] hold_m [4];
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(16), .DW(16), .PRIO_MODE(0)) dut_rr (
        .clk(clk), .rst(rst),
        .req0(req0[0]), .we0(we0[0]), .addr0(addr0[0]), .wdata0(wdata0[0]),
        .gnt0(gnt0[0]), .rvalid0(rvalid0[0]), .rdata0(rdata0[0]),
        .req1(req1[0]), .we1(we1[0]), .addr1(addr1[0]), .wdata1(wdata1[0]),
        .gnt1(gnt1[0]), .rvalid1(rvalid1[0]), .rdata1(rdata1[0]),
        .mem_ena(mem_ena[0]), .mem_wea(mem_wea[0]), .mem_addr(mem_addr[0]),
        .mem_din(mem_din[0]), .mem_dout(mem_dout[0])
    );

    dmem_arbiter #(.AW(16), .DW(16), .PRIO_MODE(1)) dut_fx (
        .clk(clk), .rst(rst),
        .req0(req0[1]), .we0(we0[1]), .addr0(addr0[1]), .wdata0(wdata0[1]),
        .gnt0(gnt0[1]), .rvalid0(rvalid0[1]), .rdata0(rdata0[1]),
        .req1(req1[1]), .we1(we1[1]), .addr1(addr1[1]), .wdata1(wdata1[1]),
        .gnt1(gnt1[1]), .rvalid1(rvalid1[1]), .rdata1(rdata1[1]),
        .mem_ena(mem_ena[1]), .mem_wea(mem_wea[1]), .mem_addr(mem_addr[1]),
        .mem_din(mem_din[1]), .mem_dout(mem_dout[1])
    );

    // Write-first single-port BRAM models, one per instance.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mem_ena[d]) begin
                if (mem_wea[d]) begin
                    mem[d][mem_addr[d][7:0]] <= mem_din[d];
                    mem_dout[d]              <= mem_din[d];
                end else begin
                    mem_dout[d] <= mem[d][mem_addr[d][7:0]];
                end
            end
        end
    end

    task automatic chk(input string name, input int d, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s dut%0d t=%0t: got %h expected %h", name, d, $time, act, exp);
        end
    endtask

    // One access cycle: drive, check grant/BRAM drive at negedge, queue expected read data.
    task automatic cyc(input int d,
                       input logic r0, input logic w0, input logic [15:0] a0, input logic [15:0] wd0,
                       input logic r1, input logic w1, input logic [15:0] a1, input logic [15:0] wd1,
                       input logic eg0, input logic eg1,
                       input logic [15:0] e0, input logic [15:0] e1);
        logic [15:0] ea, ed;
        logic        ew;
        req0[d] = r0; we0[d] = w0; addr0[d] = a0; wdata0[d] = wd0;
        req1[d] = r1; we1[d] = w1; addr1[d] = a1; wdata1[d] = wd1;
        ea = eg0 ? a0 : (eg1 ? a1 : 16'h0);
        ed = eg0 ? wd0 : (eg1 ? wd1 : 16'h0);
        ew = eg0 ? w0 : (eg1 ? w1 : 1'b0);
        @(negedge clk);
        chk("gnt0", d, 16'(gnt0[d]), 16'(eg0));
        chk("gnt1", d, 16'(gnt1[d]), 16'(eg1));
        chk("mem_ena", d, 16'(mem_ena[d]), 16'(eg0 | eg1));
        chk("mem_wea", d, 16'(mem_wea[d]), 16'(ew));
        chk("mem_addr", d, mem_addr[d], ea);
        chk("mem_din", d, mem_din[d], ed);
        if (eg0 && !w0) q[d*2].push_back(e0);
        if (eg1 && !w1) q[d*2+1].push_back(e1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int d);
        cyc(d, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
    endtask

    initial begin
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req0[d] = 1'b1; we0[d] = 1'b0; addr0[d] = 16'h0; wdata0[d] = 16'h0;
            req1[d] = 1'b1; we1[d] = 1'b0; addr1[d] = 16'h0; wdata1[d] = 16'h0;
        end
        for (int i = 0; i < 4; i++) hold_m[i] = 16'h0;
        fork
            forever begin
                @(negedge clk);
                for (int i = 0; i < 4; i++) begin
                    int d;
                    logic rv;
                    logic [15:0] rd, e;
                    d  = i / 2;
                    rv = (i % 2 == 1) ? rvalid1[d] : rvalid0[d];
                    rd = (i % 2 == 1) ? rdata1[d] : rdata0[d];
                    if (!rst) begin
                        q[i].delete();
                        hold_m[i] = 16'h0;
                        chk("rvalid_in_reset", i, 16'(rv), 16'h0);
                        chk("rdata_in_reset", i, rd, 16'h0);
                    end else if (rv) begin
                        if (q[i].size() == 0) begin
                            chk("unexpected_rvalid", i, 16'(rv), 16'h0);
                        end else begin
                            e = q[i].pop_front();
                            chk("rdata", i, rd, e);
                            hold_m[i] = e;
                        end
                    end else begin
                        chk("rdata_hold", i, rd, hold_m[i]);
                    end
                end
                for (int d = 0; d < 2; d++)
                    if (gnt0[d] | gnt1[d]) chk("gnt_exclusive", d, 16'(gnt0[d] & gnt1[d]), 16'h0);
            end
            begin
                // Reset with both ports requesting.
                @(negedge clk);
                for (int d = 0; d < 2; d++) begin
                    chk("rst_gnt0", d, 16'(gnt0[d]), 16'h0);
                    chk("rst_gnt1", d, 16'(gnt1[d]), 16'h0);
                    chk("rst_mem_ena", d, 16'(mem_ena[d]), 16'h0);
                    chk("rst_mem_addr", d, mem_addr[d], 16'h0);
                end
                @(posedge clk); #1;
                rst = 1'b1;
                req0[1] = 1'b0; req1[1] = 1'b0;
                // Round-robin instance: first tie goes to port 1.
                cyc(0, 1, 1, 16'h0001, 16'h1111, 1, 1, 16'h0002, 16'h2222, 0, 1, 16'h0, 16'h0);
                cyc(0, 1, 1, 16'h0001, 16'h1111, 0, 0, 16'h0, 16'h0, 1, 0, 16'h0, 16'h0);
                cyc(0, 1, 1, 16'h0010, 16'hBEEF, 0, 0, 16'h0, 16'h0, 1, 0, 16'h0, 16'h0);
                cyc(0, 1, 0, 16'h0010, 16'h0000, 0, 0, 16'h0, 16'h0, 1, 0, 16'hBEEF, 16'h0);
                idle(0); idle(0);
                cyc(0, 0, 0, 16'h0, 16'h0, 1, 1, 16'h0003, 16'h000A, 0, 1, 16'h0, 16'h0);
                cyc(0, 0, 0, 16'h0, 16'h0, 1, 1, 16'h0004, 16'h000B, 0, 1, 16'h0, 16'h0);
                cyc(0, 0, 0, 16'h0, 16'h0, 1, 1, 16'h0005, 16'h000C, 0, 1, 16'h0, 16'h0);
                // Continuous contention after a port-1 grant: 0,1,0,1.
                for (int k = 0; k < 4; k++)
                    cyc(0, 1, 0, 16'h0001, 16'h0, 1, 0, 16'h0002, 16'h0,
                        (k % 2 == 0), (k % 2 == 1), 16'h1111, 16'h2222);
                cyc(0, 0, 0, 16'h0, 16'h0, 1, 0, 16'h0003, 16'h0, 0, 1, 16'h0, 16'h000A);
                cyc(0, 0, 0, 16'h0, 16'h0, 1, 0, 16'h0004, 16'h0, 0, 1, 16'h0, 16'h000B);
                cyc(0, 0, 0, 16'h0, 16'h0, 1, 0, 16'h0005, 16'h0, 0, 1, 16'h0, 16'h000C);
                idle(0);
                // Read-after-write on consecutive grants.
                cyc(0, 1, 1, 16'h0020, 16'h5A5A, 0, 0, 16'h0, 16'h0, 1, 0, 16'h0, 16'h0);
                cyc(0, 1, 0, 16'h0020, 16'h0000, 0, 0, 16'h0, 16'h0, 1, 0, 16'h5A5A, 16'h0);
                idle(0); idle(0);
                // Fixed-priority instance: port 0 always wins, port 1 held.
                for (int k = 0; k < 4; k++)
                    cyc(1, 1, 1, 16'h0030 + 16'(k), 16'h0001 + 16'(k), 1, 1, 16'h0040, 16'h7777,
                        1, 0, 16'h0, 16'h0);
                cyc(1, 0, 0, 16'h0, 16'h0, 1, 1, 16'h0040, 16'h7777, 0, 1, 16'h0, 16'h0);
                cyc(1, 1, 0, 16'h0032, 16'h0, 1, 0, 16'h0040, 16'h0, 1, 0, 16'h0003, 16'h0);
                cyc(1, 0, 0, 16'h0, 16'h0, 1, 0, 16'h0040, 16'h0, 0, 1, 16'h0, 16'h7777);
                idle(1); idle(1);
                // Reset in the cycle after a read grant drops the return.
                cyc(0, 1, 0, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0, 1, 0, 16'hBEEF, 16'h0);
                rst = 1'b0;
                req0[0] = 1'b0;
                @(negedge clk);
                chk("midrst_rvalid0", 0, 16'(rvalid0[0]), 16'h0);
                chk("midrst_rdata0", 0, rdata0[0], 16'h0);
                @(posedge clk); #1;
                @(posedge clk); #1;
                rst = 1'b1;
                idle(0);
                cyc(0, 1, 0, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0, 1, 0, 16'hBEEF, 16'h0);
                idle(0); idle(0);
                for (int i = 0; i < 4; i++) chk("queue_drained", i, 16'(q[i].size()), 16'h0);
            end
        join_any
        disable fork;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
